// File: rtl/gpio_apb.sv
// APB GPIO: per-pin direction, output data with atomic set/clear, synchronised inputs, edge interrupts.
// One APB wait state (PREADY registered, pulses one cycle after the access edge); no other stalls.
module gpio_apb #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic [4:0]       PADDR,
    input  logic             PWRITE,
    input  logic             PENABLE,
    input  logic [31:0]      PWDATA,
    input  logic             PSEL,
    output logic [31:0]      PRDATA,
    output logic             PREADY,
    input  logic [WIDTH-1:0] gpio_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    localparam logic [2:0] A_DIR  = 3'd0;
    localparam logic [2:0] A_ODR  = 3'd1;
    localparam logic [2:0] A_IDR  = 3'd2;
    localparam logic [2:0] A_BSR  = 3'd3;
    localparam logic [2:0] A_IER  = 3'd4;
    localparam logic [2:0] A_EDGE = 3'd5;
    localparam logic [2:0] A_ISR  = 3'd6;

    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] odr_q, odr_d;
    logic [WIDTH-1:0] ier_q, ier_d;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [WIDTH-1:0] isr_q, isr_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [31:0]      prdata_q, prdata_d;
    logic             pready_q, pready_d;

    logic             access, wr_en, rd_en;
    logic [2:0]       addr;
    logic [WIDTH-1:0] sync, det, bsr_set, bsr_clr, w1c;
    logic [31:0]      rdata;
    logic             unused_bits;

    assign unused_bits = ^{PADDR[1:0], PWDATA};

    function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
        zext = 32'(v);
    endfunction

    always_comb begin
        addr    = PADDR[4:2];
        // Gating with PREADY keeps a held access phase from writing twice.
        access  = PSEL & PENABLE & ~pready_q;
        wr_en   = access & PWRITE;
        rd_en   = access & ~PWRITE;

        sync_d  = {sync_q[SYNC_STAGES-2:0], gpio_i};
        sync    = sync_q[SYNC_STAGES-1];
        prev_d  = sync;
        det     = (edge_q & ~sync & prev_q) | (~edge_q & sync & ~prev_q);

        bsr_set = PWDATA[WIDTH-1:0];
        bsr_clr = PWDATA[16 +: WIDTH];
        w1c     = '0;

        dir_d   = dir_q;
        odr_d   = odr_q;
        ier_d   = ier_q;
        edge_d  = edge_q;

        if (wr_en) begin
            case (addr)
                A_DIR:   dir_d  = PWDATA[WIDTH-1:0];
                A_ODR:   odr_d  = PWDATA[WIDTH-1:0];
                A_BSR:   odr_d  = (odr_q & ~bsr_clr) | bsr_set;
                A_IER:   ier_d  = PWDATA[WIDTH-1:0];
                A_EDGE:  edge_d = PWDATA[WIDTH-1:0];
                A_ISR:   w1c    = PWDATA[WIDTH-1:0];
                default: ;
            endcase
        end

        // A fresh edge beats a simultaneous clear of the same bit.
        isr_d = (isr_q & ~w1c) | (ier_q & det);

        case (addr)
            A_DIR:   rdata = zext(dir_q);
            A_ODR:   rdata = zext(odr_q);
            A_IDR:   rdata = zext(sync);
            A_IER:   rdata = zext(ier_q);
            A_EDGE:  rdata = zext(edge_q);
            A_ISR:   rdata = zext(isr_q);
            default: rdata = '0;
        endcase

        prdata_d = rd_en ? rdata : prdata_q;
        pready_d = access;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            dir_q    <= '0;
            odr_q    <= '0;
            ier_q    <= '0;
            edge_q   <= '0;
            isr_q    <= '0;
            prev_q   <= '0;
            sync_q   <= '0;
            prdata_q <= '0;
            pready_q <= 1'b0;
        end else begin
            dir_q    <= dir_d;
            odr_q    <= odr_d;
            ier_q    <= ier_d;
            edge_q   <= edge_d;
            isr_q    <= isr_d;
            prev_q   <= prev_d;
            sync_q   <= sync_d;
            prdata_q <= prdata_d;
            pready_q <= pready_d;
        end
    end

    assign gpio_oe = dir_q;
    assign gpio_o  = odr_q;
    assign irq     = |(isr_q & ier_q);
    assign PRDATA  = prdata_q;
    assign PREADY  = pready_q;

endmodule

// File: doc/gpio_apb.md
# gpio_apb

Parametrised APB general-purpose I/O peripheral that succeeds the fixed 8-bit output-only port. It provides per-pin direction control, an output data register with atomic set/clear, and a synchronised input data register. It also provides per-pin edge-triggered interrupts with write-1-to-clear pending flags. It sits on the APB bus beside the other RISC-V peripherals; pad tristating is done at the top level from `gpio_o`/`gpio_oe`.

## Interface
- `WIDTH`, 8: number of pins, legal range 1..16.
- `SYNC_STAGES`, 2: input synchroniser depth, legal range 2..4.

- `PCLK` in 1: single clock; all logic is on its rising edge.
- `PRESETn` in 1: reset, asynchronous, active-low.
- `PADDR` in 5: byte address; `PADDR[4:2]` selects the register.
- `PWRITE` in 1: APB write.
- `PENABLE` in 1: APB access phase.
- `PWDATA` in 32: write data.
- `PSEL` in 1: slave select.
- `PRDATA` out 32: read data.
- `PREADY` out 1: transfer complete.
- `gpio_i` in WIDTH: raw pad inputs, asynchronous to `PCLK`.
- `gpio_o` out WIDTH: pad output values.
- `gpio_oe` out WIDTH: pad output enables; 1 = drive.
- `irq` out 1: level interrupt request.

## Operation
Register map (unused upper bits read 0 and ignore writes):
- 0x00 DIR, RW: 1 = output. `gpio_oe = DIR`.
- 0x04 ODR, RW: `gpio_o = ODR`.
- 0x08 IDR, RO: synchronised pin values; this reflects the pins in both directions.
- 0x0C BSR, WO, reads 0:
  - `PWDATA[WIDTH-1:0]` sets ODR bits.
  - `PWDATA[16+WIDTH-1:16]` clears ODR bits.
  - If a set and a clear hit the same bit, set wins.
- 0x10 IER, RW: per-pin interrupt enable.
- 0x14 EDGE, RW: 0 = rising edge, 1 = falling edge.
- 0x18 ISR, RW1C: pending flags. Writing 1 clears a bit; writing 0 has no effect.
- 0x1C reserved: reads 0, writes ignored.

Input path:
- `gpio_i` passes through `SYNC_STAGES` flops to produce `sync`. IDR reads `sync`.
- `prev` is `sync` delayed by one cycle.
- Rising edge: `sync & ~prev`. Falling edge: `~sync & prev`. EDGE selects between them per bit.
- ISR bit sets only when its IER bit is 1 and the selected edge is detected on that cycle.
- Clearing IER does not clear an ISR bit that is already pending.
- If an edge detection and a W1C of the same bit occur in the same cycle, set wins.
- `irq = |(ISR & IER)`. This is combinational from registers, so it has no glitch-prone input path.

APB handshake (one wait state):
- Register access occurs on the edge where `PSEL & PENABLE & ~PREADY`.
  - A write updates the addressed register on that edge.
  - A read captures `PRDATA` on that edge.
- `PREADY` is registered and goes high for exactly one cycle after that edge. It is low in all other cycles.
- The `~PREADY` term prevents a double write within a single transfer.
- `PRDATA` holds its last value between reads.

Reset (`PRESETn` low, immediate):
- DIR, ODR, IER, EDGE, ISR, the synchroniser chain, `prev`, `PRDATA` and `PREADY` all go to 0.
- Therefore `gpio_oe = 0`, `gpio_o = 0` and `irq = 0`.
- Reset asserted mid-transfer aborts it: no write lands and `PREADY` stays 0 until a new transfer occurs.

## Timing
- An APB transfer takes 3 cycles: setup, then access with `PREADY` low, then access with `PREADY` high.
- DIR/ODR/BSR writes reach `gpio_oe`/`gpio_o` one cycle after the access edge, which is the same cycle `PREADY` is high.
- Pin change to IDR: `SYNC_STAGES` rising edges.
- Pin change to ISR set and `irq` high: `SYNC_STAGES`+1 edges.
- W1C of ISR: `irq` falls in the cycle after the access edge, unless another enabled flag is still pending or the set-wins rule re-sets the bit.
- An IER write changes `irq` in the cycle after the access edge.

## Test plan
- **Reset defaults.** Reset, then read all addresses. Required: 0 everywhere; `gpio_oe = 0`, `irq = 0`.
- **Direction and output with readback.** WIDTH=8. Write DIR=0xF0 and ODR=0xA5. Required: `gpio_oe = 0xF0`, `gpio_o = 0xA5`. With `gpio_i` looped back through the pad model, IDR reads 0xA0 in its upper nibble.
- **BSR set/clear.** ODR=0x0F. Write BSR=0x0003_00C0. Required: ODR=0xCC. Then write BSR=0x0001_0001. Required: bit 0 stays 1 (set wins).
- **Rising-edge interrupt and latency.** IER=0x01, EDGE=0. Raise `gpio_i[0]`. Required: IDR[0]=1 after 2 edges; ISR[0] and `irq` are 1 after 3 edges. Write ISR=0x01: `irq` falls the next cycle.
- **Falling edge and masking.** Set EDGE[3]=1 and IER[3]=0, then toggle pin 3 high then low. Required: ISR stays 0. Set IER[3]=1 and repeat. Required: ISR=0x08 only after the fall.
- **Collision and reset mid-transfer.** W1C of ISR[0] issued on the same cycle as a new edge on pin 0. Required: ISR[0] remains 1. Asserting `PRESETn` low during a write access phase to ODR. Required: ODR=0 and `PREADY` never pulses.
